// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate sequencer and its next-count slice.
package gate_seq_pkg;

  localparam int unsigned CW_DEF = 16;
  localparam int unsigned SW_DEF = 8;

  localparam int ST_IDLE = 0;
  localparam int ST_SYNC = 1;
  localparam int ST_GDEL = 2;
  localparam int ST_GATE = 3;
  localparam int ST_LEN  = 4;

  localparam logic [4:0] OH_IDLE = 5'(1 << ST_IDLE);
  localparam logic [4:0] OH_SYNC = 5'(1 << ST_SYNC);
  localparam logic [4:0] OH_GDEL = 5'(1 << ST_GDEL);
  localparam logic [4:0] OH_GATE = 5'(1 << ST_GATE);
  localparam logic [4:0] OH_LEN  = 5'(1 << ST_LEN);

  typedef enum logic [4:0] {
    StIdle = OH_IDLE,
    StSync = OH_SYNC,
    StGdel = OH_GDEL,
    StGate = OH_GATE,
    StLen  = OH_LEN
  } state_e;

  typedef logic [CW_DEF-1:0] cnt_t;

endpackage

// File: rtl/gate_seq_cnt.sv
// Loadable down-counter that saturates at zero; clr beats load beats decrement.
module gate_seq_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         zero
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (clr) begin
      q_q <= '0;
    end else if (load) begin
      q_q <= d;
    end else if (ena && (q_q != '0)) begin
      q_q <= q_q - W'(1);
    end
  end

  assign q    = q_q;
  assign zero = (q_q == '0);

endmodule

// File: rtl/gate_seq_gen.sv
// Sync / gate-delay / gate / length sequencer with registered outputs.
// GATE_SEQ_CONT_EN: restart straight into SYNC on LEN exit instead of idling.
module gate_seq_gen
  import gate_seq_pkg::*;
#(
  parameter int unsigned CW = CW_DEF,
  parameter int unsigned SW = SW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          abort,
  input  logic [SW-1:0] Tsync,
  input  logic [SW-1:0] Tgdel,
  input  logic [CW-1:0] Tgate,
  input  logic [CW-1:0] Tlen,
  output logic [4:0]    state,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] cnt_len,
  output logic          Sync,
  output logic          Gate,
  output logic          Done
);

  state_e state_q, state_d;
  logic   sync_q, sync_d, gate_q, gate_d, done_q, done_d;

  logic          cnt_dec, cnt_load, cnt_clr, cnt_zero;
  logic [CW-1:0] cnt_ld_val;
  logic          len_dec, len_load, len_clr, len_zero;

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    cnt_dec    = 1'b0;
    cnt_load   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_ld_val = '0;
    len_dec    = 1'b0;
    len_load   = 1'b0;
    len_clr    = 1'b0;
    if (abort) begin
      state_d = StIdle;
      cnt_clr = 1'b1;
      len_clr = 1'b1;
    end else if (ena) begin
      len_dec = ~state_q[ST_IDLE];
      unique case (state_q)
        StIdle: begin
          state_d    = StSync;
          cnt_load   = 1'b1;
          cnt_ld_val = CW'(Tsync);
          len_load   = 1'b1;
        end
        StSync: begin
          if (cnt_zero) begin
            state_d    = StGdel;
            cnt_load   = 1'b1;
            cnt_ld_val = CW'(Tgdel);
          end else begin
            cnt_dec = 1'b1;
          end
        end
        StGdel: begin
          if (cnt_zero) begin
            state_d    = StGate;
            cnt_load   = 1'b1;
            cnt_ld_val = Tgate;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        StGate: begin
          if (cnt_zero) begin
            state_d = StLen;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        StLen: begin
          if (len_zero) begin
            done_d = 1'b1;
`ifdef GATE_SEQ_CONT_EN
            state_d    = StSync;
            cnt_load   = 1'b1;
            cnt_ld_val = CW'(Tsync);
            len_load   = 1'b1;
`else
            state_d = StIdle;
`endif
          end
        end
        default: begin
          // Non-one-hot code: drop back to a clean IDLE.
          state_d = StIdle;
          cnt_clr = 1'b1;
          len_clr = 1'b1;
        end
      endcase
    end
  end

  assign sync_d = state_d[ST_SYNC];
  assign gate_d = state_d[ST_GATE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sync_q  <= 1'b0;
      gate_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      gate_q  <= gate_d;
      done_q  <= done_d;
    end
  end

  gate_seq_cnt #(
    .W(CW)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (cnt_dec),
    .load (cnt_load),
    .clr  (cnt_clr),
    .d    (cnt_ld_val),
    .q    (cnt),
    .zero (cnt_zero)
  );

  gate_seq_cnt #(
    .W(CW)
  ) u_cnt_len (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (len_dec),
    .load (len_load),
    .clr  (len_clr),
    .d    (Tlen),
    .q    (cnt_len),
    .zero (len_zero)
  );

  assign state = state_q;
  assign Sync  = sync_q;
  assign Gate  = gate_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_gate_seq_gen.sv
// Directed self-checking bench for gate_seq_gen (single-shot or GATE_SEQ_CONT_EN build).
module tb_gate_seq_gen;

  localparam logic [4:0] IDLE = 5'b00001;
  localparam logic [4:0] SYNC = 5'b00010;
  localparam logic [4:0] GDEL = 5'b00100;
  localparam logic [4:0] GATE = 5'b01000;
  localparam logic [4:0] LEN  = 5'b10000;

  logic        clk = 1'b0;
  logic        rst_n, ena, abort;
  logic [7:0]  Tsync, Tgdel;
  logic [15:0] Tgate, Tlen;
  logic [4:0]  state;
  logic [15:0] cnt, cnt_len;
  logic        Sync, Gate, Done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gate_seq_gen #(
    .CW(16),
    .SW(8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .abort  (abort),
    .Tsync  (Tsync),
    .Tgdel  (Tgdel),
    .Tgate  (Tgate),
    .Tlen   (Tlen),
    .state  (state),
    .cnt    (cnt),
    .cnt_len(cnt_len),
    .Sync   (Sync),
    .Gate   (Gate),
    .Done   (Done)
  );

  // Expected phase for the k-th enabled edge after start (k=1 is the IDLE->SYNC edge).
  function automatic logic [4:0] exp_state(int k, int ls, int lg, int lt, int ll);
    if (k <= ls) return SYNC;
    if (k <= ls + lg) return GDEL;
    if (k <= ls + lg + lt) return GATE;
    if (k <= ls + lg + lt + ll) return LEN;
    return IDLE;
  endfunction

  function automatic logic [15:0] exp_cnt(int k, int ls, int lg, int lt);
    if (k <= ls) return 16'(ls - k);
    if (k <= ls + lg) return 16'(ls + lg - k);
    if (k <= ls + lg + lt) return 16'(ls + lg + lt - k);
    return 16'd0;
  endfunction

  function automatic logic [15:0] exp_len(int k, int tlen);
    return (tlen - k + 1 > 0) ? 16'(tlen - k + 1) : 16'd0;
  endfunction

  function automatic logic [39:0] expv(logic [4:0] s, logic [15:0] c, logic [15:0] l, logic d);
    return {s, c, l, s[1], s[3], d};
  endfunction

  task automatic cleanup();
    ena   = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [39:0] got;
    rst_n = 1'b1; ena = 1'b0; abort = 1'b0;
    Tsync = 8'd0; Tgdel = 8'd0; Tgate = 16'd0; Tlen = 16'd0;
    #2 rst_n = 1'b0;
    #1;
    got = {state, cnt, cnt_len, Sync, Gate, Done};
    n_checks++;
    if (got !== expv(IDLE, 16'd0, 16'd0, 1'b0)) begin
      n_fail++; $display("FAIL reset_value got=%h exp=%h", got, expv(IDLE, 16'd0, 16'd0, 1'b0));
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    Tlen = 16'd9;
    repeat (2) @(posedge clk);
    #1;
    got = {state, cnt, cnt_len, Sync, Gate, Done};
    n_checks++;
    if (got !== expv(IDLE, 16'd0, 16'd0, 1'b0)) begin
      n_fail++; $display("FAIL reset_idle_hold got=%h exp=%h", got, expv(IDLE, 16'd0, 16'd0, 1'b0));
    end
  endtask

  task automatic test_basic();
    logic [39:0] got, exp;
    Tsync = 8'd2; Tgdel = 8'd1; Tgate = 16'd3; Tlen = 16'd20;
    ena = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk); #1;
      exp = expv(exp_state(k, 3, 2, 4, 12), exp_cnt(k, 3, 2, 4), exp_len(k, 20), 1'b0);
      got = {state, cnt, cnt_len, Sync, Gate, Done};
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL basic k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    @(posedge clk); #1;
`ifdef GATE_SEQ_CONT_EN
    exp = expv(SYNC, 16'd2, 16'd20, 1'b1);
`else
    exp = expv(IDLE, 16'd0, 16'd0, 1'b1);
`endif
    got = {state, cnt, cnt_len, Sync, Gate, Done};
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL basic_done got=%h exp=%h", got, exp);
    end
    ena = 1'b0;
    @(posedge clk); #1;
    exp[0] = 1'b0;
    got = {state, cnt, cnt_len, Sync, Gate, Done};
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL basic_after_done got=%h exp=%h", got, exp);
    end
    cleanup();
  endtask

  task automatic test_zero_len();
    logic [39:0] got, exp;
    Tsync = 8'd0; Tgdel = 8'd0; Tgate = 16'd0; Tlen = 16'd0;
    ena = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      exp = expv(exp_state(k, 1, 1, 1, 1), 16'd0, 16'd0, 1'b0);
      got = {state, cnt, cnt_len, Sync, Gate, Done};
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL zero_len k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    @(posedge clk); #1;
`ifdef GATE_SEQ_CONT_EN
    exp = expv(SYNC, 16'd0, 16'd0, 1'b1);
`else
    exp = expv(IDLE, 16'd0, 16'd0, 1'b1);
`endif
    got = {state, cnt, cnt_len, Sync, Gate, Done};
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL zero_len_done got=%h exp=%h", got, exp);
    end
    cleanup();
  endtask

  task automatic test_pause();
    logic [39:0] got, exp;
    Tsync = 8'd2; Tgdel = 8'd1; Tgate = 16'd3; Tlen = 16'd20;
    ena = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk); #1;
      exp = expv(exp_state(k, 3, 2, 4, 12), exp_cnt(k, 3, 2, 4), exp_len(k, 20), 1'b0);
      got = {state, cnt, cnt_len, Sync, Gate, Done};
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL pause k=%0d got=%h exp=%h", k, got, exp);
      end
      if (k == 7) begin
        // Mid-GATE freeze; timing inputs are scrambled as they are not sampled now.
        ena = 1'b0;
        Tsync = 8'd99; Tgdel = 8'd99; Tgate = 16'd99; Tlen = 16'd99;
        for (int p = 0; p < 5; p++) begin
          @(posedge clk); #1;
          got = {state, cnt, cnt_len, Sync, Gate, Done};
          n_checks++;
          if (got !== exp) begin
            n_fail++; $display("FAIL pause_frozen p=%0d got=%h exp=%h", p, got, exp);
          end
        end
        Tsync = 8'd2; Tgdel = 8'd1; Tgate = 16'd3; Tlen = 16'd20;
        ena = 1'b1;
      end
    end
    @(posedge clk); #1;
`ifdef GATE_SEQ_CONT_EN
    exp = expv(SYNC, 16'd2, 16'd20, 1'b1);
`else
    exp = expv(IDLE, 16'd0, 16'd0, 1'b1);
`endif
    got = {state, cnt, cnt_len, Sync, Gate, Done};
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL pause_done got=%h exp=%h", got, exp);
    end
    cleanup();
  endtask

  task automatic test_abort();
    logic [39:0] got, exp;
    Tsync = 8'd0; Tgdel = 8'd1; Tgate = 16'd3; Tlen = 16'd20;
    ena = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp = expv(GDEL, 16'd1, 16'd19, 1'b0);
    got = {state, cnt, cnt_len, Sync, Gate, Done};
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL abort_setup got=%h exp=%h", got, exp);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    exp = expv(IDLE, 16'd0, 16'd0, 1'b0);
    got = {state, cnt, cnt_len, Sync, Gate, Done};
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL abort_gdel got=%h exp=%h", got, exp);
    end
    abort = 1'b0; ena = 1'b0;
    @(posedge clk); #1;
    got = {state, cnt, cnt_len, Sync, Gate, Done};
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL abort_idle_hold got=%h exp=%h", got, exp);
    end
    ena = 1'b1;
    @(posedge clk); #1;
    exp = expv(SYNC, 16'd0, 16'd20, 1'b0);
    got = {state, cnt, cnt_len, Sync, Gate, Done};
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL abort_restart got=%h exp=%h", got, exp);
    end
    cleanup();
    // Abort coinciding with the LEN exit edge suppresses Done.
    Tsync = 8'd0; Tgdel = 8'd0; Tgate = 16'd0; Tlen = 16'd0;
    ena = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    exp = expv(LEN, 16'd0, 16'd0, 1'b0);
    got = {state, cnt, cnt_len, Sync, Gate, Done};
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL abort_len_setup got=%h exp=%h", got, exp);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    exp = expv(IDLE, 16'd0, 16'd0, 1'b0);
    got = {state, cnt, cnt_len, Sync, Gate, Done};
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL abort_len_exit got=%h exp=%h", got, exp);
    end
    abort = 1'b0;
    // Asynchronous reset in the middle of a run.
    Tsync = 8'd5; Tlen = 16'd20;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    got = {state, cnt, cnt_len, Sync, Gate, Done};
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL async_reset got=%h exp=%h", got, exp);
    end
    ena = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_overrun();
    logic [39:0] got, exp;
    Tsync = 8'd0; Tgdel = 8'd0; Tgate = 16'd30; Tlen = 16'd5;
    ena = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk); #1;
      exp = expv(exp_state(k, 1, 1, 31, 1), exp_cnt(k, 1, 1, 31), exp_len(k, 5), 1'b0);
      got = {state, cnt, cnt_len, Sync, Gate, Done};
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL overrun k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    @(posedge clk); #1;
`ifdef GATE_SEQ_CONT_EN
    exp = expv(SYNC, 16'd0, 16'd5, 1'b1);
`else
    exp = expv(IDLE, 16'd0, 16'd0, 1'b1);
`endif
    got = {state, cnt, cnt_len, Sync, Gate, Done};
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL overrun_done got=%h exp=%h", got, exp);
    end
    cleanup();
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    d1 = 22;
`ifdef GATE_SEQ_CONT_EN
    d2 = 43;
`else
    d2 = 44;
`endif
    Tsync = 8'd2; Tgdel = 8'd1; Tgate = 16'd3; Tlen = 16'd20;
    ena = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (Done !== ((k == d1) || (k == d2))) begin
        n_fail++; $display("FAIL b2b_done k=%0d got=%b exp=%b", k, Done, (k == d1) || (k == d2));
      end
      if (k == d1 + 1) begin
        n_checks++;
        if (Sync !== 1'b1) begin
          n_fail++; $display("FAIL b2b_resync k=%0d got=%b exp=1", k, Sync);
        end
      end
    end
    cleanup();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_pause();
    test_abort();
    test_overrun();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout reached before end of test");
    $fatal(1);
  end

endmodule
